// File: rtl/bp_update_unit.sv
// Branch-predictor update unit: queues resolved EX branches for the
// predictor tables and raises a one-cycle mispredict/redirect pulse.
// Optional statistics counters are enabled with the BP_UPD_STATS_EN macro.
module bp_update_unit #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             branch_en_EX,
  input  logic [WIDTH-1:0] PC_EX,
  input  logic [WIDTH-1:0] PC_destination,
  input  logic             feedback_from_ALU,
  input  logic             pred_taken_EX,
  input  logic [WIDTH-1:0] pred_target_EX,
  input  logic             upd_ready,
  output logic             upd_valid,
  output logic [WIDTH-1:0] upd_PC,
  output logic             upd_taken,
  output logic [WIDTH-1:0] upd_target,
  output logic             mispredict,
  output logic [WIDTH-1:0] redirect_PC,
  output logic             stall_EX,
  output logic [31:0]      branch_cnt,
  output logic [31:0]      mispredict_cnt
);

  localparam int unsigned AW = $clog2(DEPTH);

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t           state_q, state_d;
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             mispredict_q, mispredict_d;
  logic [WIDTH-1:0] redirect_q, redirect_d;

  logic [WIDTH-1:0] pc_mem_q  [DEPTH];
  logic [WIDTH-1:0] tgt_mem_q [DEPTH];
  logic [DEPTH-1:0] tk_mem_q;

  logic full, empty, push, pop, mis_cond;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign pop   = (state_q == ACTIVE) && upd_ready;
  assign push  = branch_en_EX && (!full || pop);

  assign mis_cond = branch_en_EX &&
                    ((feedback_from_ALU != pred_taken_EX) ||
                     (feedback_from_ALU && (PC_destination != pred_target_EX)));

  // Pointer, FSM and mispredict next-state logic.
  always_comb begin
    wr_ptr_d     = wr_ptr_q + (AW+1)'(push);
    rd_ptr_d     = rd_ptr_q + (AW+1)'(pop);
    state_d      = state_q;
    mispredict_d = mis_cond;
    redirect_d   = redirect_q;
    if (mis_cond) begin
      redirect_d = feedback_from_ALU ? PC_destination : PC_EX + WIDTH'(4);
    end
    case (state_q)
      IDLE:   if (push) state_d = ACTIVE;
      ACTIVE: if (pop && !push && (rd_ptr_d == wr_ptr_q)) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Control state register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= IDLE;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      mispredict_q <= 1'b0;
      redirect_q   <= '0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      mispredict_q <= mispredict_d;
      redirect_q   <= redirect_d;
    end
  end

  // Queue storage; contents are left unreset, pointers define validity.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem_q[wr_ptr_q[AW-1:0]]  <= PC_EX;
      tgt_mem_q[wr_ptr_q[AW-1:0]] <= PC_destination;
      tk_mem_q[wr_ptr_q[AW-1:0]]  <= feedback_from_ALU;
    end
  end

  assign upd_valid   = (state_q == ACTIVE);
  assign upd_PC      = pc_mem_q[rd_ptr_q[AW-1:0]];
  assign upd_target  = tgt_mem_q[rd_ptr_q[AW-1:0]];
  assign upd_taken   = tk_mem_q[rd_ptr_q[AW-1:0]];
  assign stall_EX    = full;
  assign mispredict  = mispredict_q;
  assign redirect_PC = redirect_q;

`ifdef BP_UPD_STATS_EN
  logic [31:0] branch_cnt_q, branch_cnt_d;
  logic [31:0] mispredict_cnt_q, mispredict_cnt_d;

  // Statistics next-state: every EX branch counts, dropped or not.
  always_comb begin
    branch_cnt_d     = branch_cnt_q + 32'(branch_en_EX);
    mispredict_cnt_d = mispredict_cnt_q + 32'(mis_cond);
  end

  // Statistics counter registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      branch_cnt_q     <= '0;
      mispredict_cnt_q <= '0;
    end else begin
      branch_cnt_q     <= branch_cnt_d;
      mispredict_cnt_q <= mispredict_cnt_d;
    end
  end

  assign branch_cnt     = branch_cnt_q;
  assign mispredict_cnt = mispredict_cnt_q;
`else
  assign branch_cnt     = '0;
  assign mispredict_cnt = '0;
`endif

  // Guard against the queue state and FSM ever disagreeing.
  always_ff @(posedge clk) begin
    if (rst) assert (empty == (state_q == IDLE));
  end

endmodule

// File: tb/tb_bp_update_unit.sv
// Self-checking bench for bp_update_unit: a queue-based reference model
// compared every cycle, plus directed literal expectations.
module tb_bp_update_unit;

  localparam int unsigned W = 32;
  localparam int unsigned D = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         branch_en_EX = 1'b0;
  logic [W-1:0] PC_EX = '0;
  logic [W-1:0] PC_destination = '0;
  logic         feedback_from_ALU = 1'b0;
  logic         pred_taken_EX = 1'b0;
  logic [W-1:0] pred_target_EX = '0;
  logic         upd_ready = 1'b0;
  logic         upd_valid;
  logic [W-1:0] upd_PC;
  logic         upd_taken;
  logic [W-1:0] upd_target;
  logic         mispredict;
  logic [W-1:0] redirect_PC;
  logic         stall_EX;
  logic [31:0]  branch_cnt;
  logic [31:0]  mispredict_cnt;

  bp_update_unit #(.WIDTH(W), .DEPTH(D)) dut (
    .clk(clk), .rst(rst), .branch_en_EX(branch_en_EX), .PC_EX(PC_EX),
    .PC_destination(PC_destination), .feedback_from_ALU(feedback_from_ALU),
    .pred_taken_EX(pred_taken_EX), .pred_target_EX(pred_target_EX),
    .upd_ready(upd_ready), .upd_valid(upd_valid), .upd_PC(upd_PC),
    .upd_taken(upd_taken), .upd_target(upd_target), .mispredict(mispredict),
    .redirect_PC(redirect_PC), .stall_EX(stall_EX), .branch_cnt(branch_cnt),
    .mispredict_cnt(mispredict_cnt)
  );

  always #5 clk = ~clk;

  int unsigned n_pass = 0;
  int unsigned n_total = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: list of pending branch records plus pulse/counters.
  typedef struct {
    logic [W-1:0] pc;
    logic         tk;
    logic [W-1:0] tg;
  } ent_t;

  ent_t         mq[$];
  logic         m_mis = 1'b0;
  logic [W-1:0] m_red = '0;
  logic [31:0]  m_bc = '0;
  logic [31:0]  m_mc = '0;

  always @(posedge clk) begin
    bit do_pop, do_push, wrong;
    ent_t e;
    if (!rst) begin
      mq.delete();
      m_mis = 1'b0;
      m_red = '0;
      m_bc  = '0;
      m_mc  = '0;
    end else begin
      do_pop  = (mq.size() > 0) && upd_ready;
      do_push = branch_en_EX && ((mq.size() < D) || do_pop);
      wrong   = branch_en_EX && ((feedback_from_ALU != pred_taken_EX) ||
                (feedback_from_ALU && PC_destination != pred_target_EX));
      m_mis = wrong;
      if (wrong) m_red = feedback_from_ALU ? PC_destination : PC_EX + 32'd4;
`ifdef BP_UPD_STATS_EN
      if (branch_en_EX) m_bc = m_bc + 1;
      if (wrong) m_mc = m_mc + 1;
`endif
      if (do_pop) void'(mq.pop_front());
      if (do_push) begin
        e.pc = PC_EX; e.tk = feedback_from_ALU; e.tg = PC_destination;
        mq.push_back(e);
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("upd_valid", 64'(upd_valid), 64'(mq.size() > 0));
      check("stall_EX", 64'(stall_EX), 64'(mq.size() == D));
      check("mispredict", 64'(mispredict), 64'(m_mis));
      check("branch_cnt", 64'(branch_cnt), 64'(m_bc));
      check("mispredict_cnt", 64'(mispredict_cnt), 64'(m_mc));
      if (m_mis) check("redirect_PC", 64'(redirect_PC), 64'(m_red));
      if (mq.size() > 0) begin
        check("upd_PC", 64'(upd_PC), 64'(mq[0].pc));
        check("upd_taken", 64'(upd_taken), 64'(mq[0].tk));
        check("upd_target", 64'(upd_target), 64'(mq[0].tg));
      end
    end
  end

  task automatic br(input logic [W-1:0] pc, input logic tk, input logic [W-1:0] dst,
                    input logic ptk, input logic [W-1:0] ptg);
    branch_en_EX = 1'b1; PC_EX = pc; feedback_from_ALU = tk;
    PC_destination = dst; pred_taken_EX = ptk; pred_target_EX = ptg;
    @(posedge clk); #1;
    branch_en_EX = 1'b0;
  endtask

  task automatic idle(input int unsigned n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    rst = 1'b0; upd_ready = 1'b0;
    idle(2);
    chk_en = 1'b1;
    @(negedge clk);
    check("rst_upd_valid", 64'(upd_valid), 64'd0);
    check("rst_mispredict", 64'(mispredict), 64'd0);
    check("rst_redirect", 64'(redirect_PC), 64'd0);
    rst = 1'b1;

    // Correctly predicted taken branch.
    upd_ready = 1'b1;
    idle(1);
    br(32'h100, 1'b1, 32'h80, 1'b1, 32'h80);
    @(negedge clk);
    check("lit_valid", 64'(upd_valid), 64'd1);
    check("lit_pc", 64'(upd_PC), 64'h100);
    check("lit_taken", 64'(upd_taken), 64'd1);
    check("lit_target", 64'(upd_target), 64'h80);
    check("lit_no_mis", 64'(mispredict), 64'd0);
    idle(2);

    // Direction mispredict: not taken but predicted taken.
    br(32'h200, 1'b0, 32'h208, 1'b1, 32'h208);
    @(negedge clk);
    check("lit_mis_dir", 64'(mispredict), 64'd1);
    check("lit_redir_nt", 64'(redirect_PC), 64'h204);
`ifdef BP_UPD_STATS_EN
    check("lit_mis_cnt", 64'(mispredict_cnt), 64'd1);
`endif
    idle(1);
    @(negedge clk);
    check("lit_mis_pulse_end", 64'(mispredict), 64'd0);
    idle(1);

    // Target mispredict on a correctly predicted taken direction.
    br(32'h400, 1'b1, 32'h300, 1'b1, 32'h304);
    @(negedge clk);
    check("lit_mis_tgt", 64'(mispredict), 64'd1);
    check("lit_redir_tgt", 64'(redirect_PC), 64'h300);
    idle(2);

    // Fill with ready low; fifth branch (also a mispredict) is dropped.
    upd_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      br(32'h500 + 32'(16 * i), 1'(i % 2), 32'h600 + 32'(8 * i),
         (i == 4) ? 1'b1 : 1'(i % 2), 32'h600 + 32'(8 * i));
      if (i == 3) begin
        @(negedge clk);
        check("lit_stall_full", 64'(stall_EX), 64'd1);
      end
    end
    upd_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("lit_drain_order", 64'(upd_PC), 64'h500 + 64'(16 * i));
      @(posedge clk); #1;
    end
    @(negedge clk);
    check("lit_drained", 64'(upd_valid), 64'd0);

    // Push and pop together while full.
    upd_ready = 1'b0;
    for (int i = 0; i < 4; i++) br(32'h700 + 32'(16 * i), 1'b1, 32'h900, 1'b1, 32'h900);
    upd_ready = 1'b1;
    br(32'h7F0, 1'b0, 32'h0, 1'b0, 32'h0);
    upd_ready = 1'b0;
    @(negedge clk);
    check("lit_full_swap_stall", 64'(stall_EX), 64'd1);
    check("lit_full_swap_head", 64'(upd_PC), 64'h710);
    upd_ready = 1'b1;
    idle(3);
    @(negedge clk);
    check("lit_full_swap_last", 64'(upd_PC), 64'h7F0);
    idle(2);

    // Back-to-back mispredicts, each with its own redirect.
    br(32'h800, 1'b0, 32'h840, 1'b1, 32'h840);
    @(negedge clk);
    check("lit_b2b_redir0", 64'(redirect_PC), 64'h804);
    br(32'h900, 1'b1, 32'hA00, 1'b0, 32'hA00);
    @(negedge clk);
    check("lit_b2b_mis1", 64'(mispredict), 64'd1);
    check("lit_b2b_redir1", 64'(redirect_PC), 64'hA00);
    idle(2);

    // Reset with entries queued.
    upd_ready = 1'b0;
    for (int i = 0; i < 3; i++) br(32'hB00 + 32'(4 * i), 1'b1, 32'hC00, 1'b0, 32'hC00);
    rst = 1'b0;
    idle(1);
    @(negedge clk);
    check("lit_rst_valid", 64'(upd_valid), 64'd0);
    check("lit_rst_stall", 64'(stall_EX), 64'd0);
    check("lit_rst_bcnt", 64'(branch_cnt), 64'd0);
    check("lit_rst_mcnt", 64'(mispredict_cnt), 64'd0);
    rst = 1'b1;

    // Mixed traffic to exercise pointer wrap and partial occupancy.
    for (int i = 0; i < 60; i++) begin
      upd_ready = 1'((i / 3) % 2);
      if ((i % 4) != 3)
        br(32'h1000 + 32'(4 * i), 1'(i % 3 == 0), 32'h2000 + 32'(i),
           1'(i % 5 == 0), 32'h2000 + 32'(i));
      else
        idle(1);
    end
    upd_ready = 1'b1;
    idle(6);
    @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/bp_update_unit.md
BP_UPDATE_UNIT -- requirements
Module: bp_update_unit

Interface
REQ-001 Parameter: WIDTH, from Header_File.svh, PC/target width.
REQ-002 Parameter: DEPTH, 4, update-queue entries; power of 2, >=2.
REQ-003 clk  in  1  single clock; all state changes on posedge.
REQ-004 rst  in  1  reset, synchronous, active-low.
REQ-005 branch_en_EX  in  1  resolved conditional branch present in EX this cycle.
REQ-006 PC_EX  in  WIDTH  PC of the EX branch.
REQ-007 PC_destination  in  WIDTH  computed target of the EX branch.
REQ-008 feedback_from_ALU  in  1  actual outcome: 1 = taken.
REQ-009 pred_taken_EX  in  1  direction predicted at fetch.
REQ-010 pred_target_EX  in  WIDTH  target predicted at fetch.
REQ-011 upd_ready  in  1  predictor tables accept the update this cycle.
REQ-012 upd_valid  out  1  update entry presented.
REQ-013 upd_PC  out  WIDTH  PC of the head entry.
REQ-014 upd_taken  out  1  outcome of the head entry.
REQ-015 upd_target  out  WIDTH  target of the head entry.
REQ-016 mispredict  out  1  one-cycle flush pulse.
REQ-017 redirect_PC  out  WIDTH  correct fetch PC, valid while mispredict=1.
REQ-018 stall_EX  out  1  queue full; EX must hold its branch.
REQ-019 branch_cnt  out  32  count of resolved branches.
REQ-020 mispredict_cnt  out  32  count of mispredicts.

Function
REQ-021 Push: branch_en_EX=1 and (not full, or pop in the same cycle) SHALL write {PC_EX, feedback_from_ALU, PC_destination} at the tail.
REQ-022 Push while full without a same-cycle pop SHALL be dropped; the queue SHALL stay unchanged.
REQ-023 Pop: upd_valid=1 and upd_ready=1 SHALL advance the head.
REQ-024 upd_PC, upd_taken and upd_target SHALL be stable while upd_valid=1 and upd_ready=0.
REQ-025 Pointers SHALL be log2(DEPTH)+1 bits wide and wrap modulo 2*DEPTH.
  - full: index bits equal, MSB differs.
  - empty: pointers equal.
REQ-026 Push and pop in the same cycle SHALL leave the occupancy unchanged at every occupancy level, including full.
REQ-027 FSM IDLE/ACTIVE:
  - IDLE: empty, upd_valid=0.
  - IDLE->ACTIVE on push.
  - ACTIVE: upd_valid=1.
  - ACTIVE->IDLE when a pop empties the queue with no same-cycle push.
REQ-028 A pushed entry SHALL appear on the upd port no earlier than the cycle after the push (1-cycle minimum latency, no bypass).
REQ-029 stall_EX SHALL be combinational from the full flag.
REQ-030 Mispredict condition: branch_en_EX=1 and (feedback_from_ALU != pred_taken_EX, or feedback_from_ALU=1 and PC_destination != pred_target_EX).
REQ-031 On that condition, mispredict SHALL pulse high for exactly the next cycle; the condition is evaluated independently of queue full or dropped push.
REQ-032 redirect_PC SHALL be registered with the pulse:
  - PC_destination if taken.
  - PC_EX+4 if not taken.
REQ-033 Back-to-back mispredicting branches SHALL produce back-to-back pulses, each carrying its own redirect_PC.
REQ-034 mispredict SHALL NOT flush the queue; resolved entries are architecturally valid.

Reset
REQ-035 rst=0 at posedge SHALL clear:
  - pointers; FSM to IDLE.
  - upd_valid, mispredict, redirect_PC, counters to 0.
REQ-036 Reset mid-operation SHALL discard all queued entries; no upd_valid in the cycle after reset.
REQ-037 Queue storage contents need not be reset.

Configuration
REQ-038 Macro BP_UPD_STATS_EN.
  - Defined: branch_cnt increments per branch_en_EX cycle, including dropped pushes.
  - Defined: mispredict_cnt increments per REQ-030 event.
  - Both counters wrap at 2^32.
REQ-039 BP_UPD_STATS_EN undefined: branch_cnt and mispredict_cnt ports SHALL exist, tied to 0; no counter flops.

Verification
REQ-040 Reset, then one branch PC=0x100, taken, target 0x80, pred taken/0x80, upd_ready=1 -> upd_valid high in the next cycle with 0x100/1/0x80; mispredict stays 0.
REQ-041 Branch PC=0x200, actual not taken, pred taken -> mispredict=1 for one cycle, redirect_PC=0x204; with BP_UPD_STATS_EN, mispredict_cnt=1.
REQ-042 upd_ready=0, five consecutive branches (DEPTH=4) -> stall_EX=1 after the 4th; 5th dropped; raise upd_ready -> exactly 4 entries drain in order.
REQ-043 Full queue, simultaneous push and pop -> occupancy stays 4; the new entry emerges last.
REQ-044 Assert rst=0 with 3 entries queued -> next cycle upd_valid=0, stall_EX=0, counters=0.
REQ-045 Taken branch, correct direction, target 0x300 vs pred 0x304 -> mispredict pulse, redirect_PC=0x300.
